// File: rtl/dmem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the data-memory arbiter:
//   - arb_state_t : FSM encoding (IDLE, ACCESS, RESP)
//   - PORT_CPU / PORT_IRQ : requester port indices
//   - ADDR_W_DEF / DATA_W_DEF / LOCK_MAX_DEF : default widths and lock bound
//   - lock_continues() : decides whether a locked beat keeps ownership
// ---------------------------------------------------------------------------
package dmem_arb_pkg;

  localparam int ADDR_W_DEF   = 8;
  localparam int DATA_W_DEF   = 8;
  localparam int LOCK_MAX_DEF = 4;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_IRQ = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  // A locked beat keeps ownership only while the beat count stays below the
  // bound; the beat that would reach the bound releases the lock.
  function automatic logic lock_continues(input logic       lock,
                                          input logic [3:0] cnt,
                                          input logic [4:0] lock_max);
    return lock && (({1'b0, cnt} + 5'd1) < lock_max);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if
// Bundle of the two requester ports, the DataMemory command/response bus and
// the arbiter status outputs.
//   p0_* : CPU execute stage (req, we, addr, wdata, lock -> ack, rdata)
//   p1_* : interrupt sequencer (same signal set as port 0)
//   mem_read/mem_write/mem_addr/mem_wdata : command towards DataMemory
//   mem_rdata : combinational read data from DataMemory
//   busy/owner : arbiter status
// Modports:
//   slave  : the arbiter side
//   master : the requester / memory side
// ---------------------------------------------------------------------------
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_lock;
  logic              p0_ack;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_lock;
  logic              p1_ack;
  logic [DATA_W-1:0] p1_rdata;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic              owner;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata, p0_lock,
    input  p1_req, p1_we, p1_addr, p1_wdata, p1_lock,
    input  mem_rdata,
    output p0_ack, p0_rdata, p1_ack, p1_rdata,
    output mem_read, mem_write, mem_addr, mem_wdata,
    output busy, owner
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata, p0_lock,
    output p1_req, p1_we, p1_addr, p1_wdata, p1_lock,
    output mem_rdata,
    input  p0_ack, p0_rdata, p1_ack, p1_rdata,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    input  busy, owner
  );

endinterface

// File: rtl/dmem_arbiter_pick.sv
// ---------------------------------------------------------------------------
// arb_pick
// Combinational two-way picker for the data-memory arbiter.
//   req[1:0]    : per-port request levels (bit 0 = CPU, bit 1 = IRQ)
//   lock_active : a lock is currently held by 'owner'
//   owner       : port holding (or last holding) the memory
//   pref        : preferred port when both request (round-robin pointer or
//                 the fixed winner, chosen by the parent)
//   grant       : selected port
//   valid       : at least one eligible request exists
// ---------------------------------------------------------------------------
module arb_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       lock_active,
  input  logic       owner,
  input  logic       pref,
  output logic       grant,
  output logic       valid
);

  // A held lock restricts eligibility to the owner. If the owner has dropped
  // its request the lock is being released this cycle, so normal arbitration
  // applies immediately.
  always_comb begin
    grant = owner;
    valid = 1'b0;
    if (lock_active && req[owner]) begin
      grant = owner;
      valid = 1'b1;
    end else if (req == 2'b11) begin
      grant = pref;
      valid = 1'b1;
    end else if (req[PORT_CPU]) begin
      grant = PORT_CPU;
      valid = 1'b1;
    end else if (req[PORT_IRQ]) begin
      grant = PORT_IRQ;
      valid = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port DataMemory between the CPU execute stage (port 0)
// and the interrupt sequencer (port 1). One transaction is in flight at a
// time: IDLE (arbitrate) -> ACCESS (drive memory) -> RESP (ack), giving a
// request-to-ack latency of two cycles and one transaction per three cycles.
// A requester may hold a lock across consecutive beats, bounded by LOCK_MAX.
//
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : dmem_arbiter_if.slave (requester ports, memory bus, busy, owner)
//
// Configuration macro:
//   DMEM_ARB_RR_EN : defined   -> round-robin on contention (rr_ptr)
//                    undefined -> FIXED_WINNER wins on contention
// ---------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int LOCK_MAX     = LOCK_MAX_DEF,
  parameter int FIXED_WINNER = 1
)(
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  arb_state_t        state;

  logic              lat_port;
  logic              lat_we;
  logic              lat_lock;

  logic              lock_active;
  logic [3:0]        lock_cnt;
  logic              owner_q;
  logic              busy_q;

  logic              mem_read_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic              p0_ack_q;
  logic              p1_ack_q;
  logic [DATA_W-1:0] p0_rdata_q;
  logic [DATA_W-1:0] p1_rdata_q;

  logic [1:0]        req_vec;
  logic              pick_grant;
  logic              pick_valid;
  logic              pref;
  logic              lock_keep;

  logic              sel_we;
  logic              sel_lock;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef DMEM_ARB_RR_EN
  logic              rr_ptr;
  assign pref = rr_ptr;
`else
  assign pref = 1'(FIXED_WINNER);
`endif

  assign req_vec   = {bus.p1_req, bus.p0_req};
  assign lock_keep = lock_continues(lat_lock, lock_cnt, 5'(LOCK_MAX));

  arb_pick u_pick (
    .req         (req_vec),
    .lock_active (lock_active),
    .owner       (owner_q),
    .pref        (pref),
    .grant       (pick_grant),
    .valid       (pick_valid)
  );

  // Request fields of whichever port the picker selects this cycle.
  always_comb begin
    sel_we    = bus.p0_we;
    sel_lock  = bus.p0_lock;
    sel_addr  = bus.p0_addr;
    sel_wdata = bus.p0_wdata;
    if (pick_grant == PORT_IRQ) begin
      sel_we    = bus.p1_we;
      sel_lock  = bus.p1_lock;
      sel_addr  = bus.p1_addr;
      sel_wdata = bus.p1_wdata;
    end
  end

  // Transaction FSM. The memory command registers double as the latched
  // address/data of the granted request; they are loaded on the grant edge so
  // they are valid throughout ACCESS and cleared again when leaving it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lat_port    <= PORT_CPU;
      lat_we      <= 1'b0;
      lat_lock    <= 1'b0;
      lock_active <= 1'b0;
      lock_cnt    <= '0;
      owner_q     <= 1'b0;
      busy_q      <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      p0_ack_q    <= 1'b0;
      p1_ack_q    <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
`ifdef DMEM_ARB_RR_EN
      rr_ptr      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // Owner walked away from its lock: release and arbitrate normally.
          if (lock_active && !req_vec[owner_q]) begin
            lock_active <= 1'b0;
            lock_cnt    <= '0;
          end
          if (pick_valid) begin
            lat_port    <= pick_grant;
            lat_we      <= sel_we;
            lat_lock    <= sel_lock;
            owner_q     <= pick_grant;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            mem_write_q <= sel_we;
            mem_read_q  <= !sel_we;
            busy_q      <= 1'b1;
            state       <= ACCESS;
          end else begin
            busy_q      <= 1'b0;
          end
        end

        ACCESS: begin
          if (!lat_we) begin
            if (lat_port == PORT_IRQ) p1_rdata_q <= bus.mem_rdata;
            else                      p0_rdata_q <= bus.mem_rdata;
          end
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
          p0_ack_q    <= (lat_port == PORT_CPU);
          p1_ack_q    <= (lat_port == PORT_IRQ);
          state       <= RESP;
        end

        RESP: begin
          p0_ack_q    <= 1'b0;
          p1_ack_q    <= 1'b0;
          lock_active <= lock_keep;
          lock_cnt    <= lock_keep ? (lock_cnt + 4'd1) : 4'd0;
          busy_q      <= lock_keep;
`ifdef DMEM_ARB_RR_EN
          // Ownership ends here, so the other port gets preference next.
          if (!lock_keep) rr_ptr <= ~lat_port;
`endif
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.p0_ack    = p0_ack_q;
  assign bus.p1_ack    = p1_ack_q;
  assign bus.p0_rdata  = p0_rdata_q;
  assign bus.p1_rdata  = p1_rdata_q;
  assign bus.busy      = busy_q;
  assign bus.owner     = owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter with a behavioural DataMemory
// (combinational read, write on the rising edge, cleared on reset with the
// interrupt vector 0x80 at address 0x01). Expected responses are queued per
// port when a request is raised and compared when that port acks.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  dmem_arbiter #(
    .ADDR_W       (8),
    .DATA_W       (8),
    .LOCK_MAX     (4),
    .FIXED_WINNER (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // DataMemory model; its reset is the complement of rst_n, i.e. rst.
  logic [7:0] mem [256];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[1] <= 8'h80;
    end else if (bus.mem_write) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  assign bus.mem_rdata = mem[bus.mem_addr];

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic       port;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  exp_t sb0[$];
  exp_t sb1[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int write_cycles = 0;
  int ack_cnt[2];
  int last_ack_cyc[2];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)",
               name, actual, required, cyc);
    end
  endtask

  task automatic setPort(input logic p, input logic req, input logic we,
                         input logic [7:0] addr, input logic [7:0] wdata,
                         input logic lock);
    if (p) begin
      bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr;
      bus.p1_wdata = wdata; bus.p1_lock = lock;
    end else begin
      bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr;
      bus.p0_wdata = wdata; bus.p0_lock = lock;
    end
  endtask

  task automatic expect_on(input logic p, input logic we,
                           input logic [7:0] addr, input logic [7:0] data);
    exp_t e;
    e.we = we; e.addr = addr; e.data = data;
    if (p) sb1.push_back(e);
    else   sb0.push_back(e);
  endtask

  // One clock; outputs are sampled 1 time unit after the rising edge and any
  // ack is matched against that port's scoreboard queue.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.mem_write) write_cycles++;
    if (bus.p0_ack) begin
      ack_cnt[0]++;
      last_ack_cyc[0] = cyc;
      if (sb0.size() == 0) checkOutput("p0_unexpected_ack", 32'(bus.p0_ack), 32'd0);
      else begin
        e = sb0.pop_front();
        if (!e.we) checkOutput($sformatf("p0_rdata@%02h", e.addr), 32'(bus.p0_rdata), 32'(e.data));
      end
    end
    if (bus.p1_ack) begin
      ack_cnt[1]++;
      last_ack_cyc[1] = cyc;
      if (sb1.size() == 0) checkOutput("p1_unexpected_ack", 32'(bus.p1_ack), 32'd0);
      else begin
        e = sb1.pop_front();
        if (!e.we) checkOutput($sformatf("p1_rdata@%02h", e.addr), 32'(bus.p1_rdata), 32'(e.data));
      end
    end
  endtask

  task automatic checkZeroOutputs(input string tag);
    checkOutput({tag, "_mem"}, 32'({bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata}), 32'd0);
    checkOutput({tag, "_ports"}, 32'({bus.p0_ack, bus.p1_ack, bus.p0_rdata, bus.p1_rdata}), 32'd0);
    checkOutput({tag, "_busy_owner"}, 32'({bus.busy, bus.owner}), 32'd0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    setPort(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    setPort(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    checkZeroOutputs("reset");
    rst = 1'b0;
    sb0.delete();
    sb1.delete();
  endtask

  // Single unlocked transaction from an idle arbiter: checks latency, the
  // number of write cycles and that the ack is a single-cycle pulse.
  task automatic applyStimulus(input vec_t v);
    int start, base, wbase, budget;
    tick();
    expect_on(v.port, v.we, v.addr, v.exp_rdata);
    setPort(v.port, 1'b1, v.we, v.addr, v.wdata, 1'b0);
    start  = cyc;
    base   = ack_cnt[v.port];
    wbase  = write_cycles;
    budget = 0;
    while (ack_cnt[v.port] == base && budget < 10) begin
      tick();
      budget++;
    end
    setPort(v.port, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    checkOutput($sformatf("p%0d_acked@%02h", v.port, v.addr), 32'(ack_cnt[v.port] - base), 32'd1);
    checkOutput($sformatf("p%0d_latency@%02h", v.port, v.addr), 32'(last_ack_cyc[v.port] - start), 32'd2);
    checkOutput($sformatf("p%0d_write_cycles@%02h", v.port, v.addr), 32'(write_cycles - wbase), 32'(v.we));
    tick();
    checkOutput($sformatf("p%0d_ack_pulse@%02h", v.port, v.addr),
                32'(v.port ? bus.p1_ack : bus.p0_ack), 32'd0);
  endtask

  initial begin
    vec_t vecs[7];
    vec_t v;
    int base0, base1, budget, b, pb, first, gap, busy_at;
    logic exp_first;

    vecs[0] = '{1'b1, 1'b0, 8'h01, 8'h00, 8'h80};
    vecs[1] = '{1'b0, 1'b1, 8'h10, 8'hAA, 8'h00};
    vecs[2] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'hAA};
    vecs[3] = '{1'b1, 1'b0, 8'h10, 8'h00, 8'hAA};
    vecs[4] = '{1'b1, 1'b1, 8'hFF, 8'h5C, 8'h00};
    vecs[5] = '{1'b0, 1'b0, 8'hFF, 8'h00, 8'h5C};
    vecs[6] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h00};

    $display("[TB] start");
    doReset();

    // Vector fetch, write/readback and address boundaries.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      if (i == 0) checkOutput("p0_rdata_hold", 32'(bus.p0_rdata), 32'd0);
    end

    // Contention from a fresh reset (rr_ptr = 0).
    doReset();
    tick();
    expect_on(1'b0, 1'b1, 8'h30, 8'h00);
    expect_on(1'b1, 1'b1, 8'h31, 8'h00);
    setPort(1'b0, 1'b1, 1'b1, 8'h30, 8'h11, 1'b0);
    setPort(1'b1, 1'b1, 1'b1, 8'h31, 8'h22, 1'b0);
    base0 = ack_cnt[0]; base1 = ack_cnt[1]; budget = 0;
    while ((ack_cnt[0] == base0 || ack_cnt[1] == base1) && budget < 20) begin
      tick();
      budget++;
      if (bus.p0_ack) setPort(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      if (bus.p1_ack) setPort(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    end
    checkOutput("contend_both_acked", 32'((ack_cnt[0] - base0) + (ack_cnt[1] - base1)), 32'd2);
`ifdef DMEM_ARB_RR_EN
    exp_first = 1'b0;
`else
    exp_first = 1'b1;
`endif
    first = (last_ack_cyc[0] < last_ack_cyc[1]) ? 0 : 1;
    gap   = (last_ack_cyc[0] < last_ack_cyc[1]) ? (last_ack_cyc[1] - last_ack_cyc[0])
                                                : (last_ack_cyc[0] - last_ack_cyc[1]);
    checkOutput("contend_first_port", 32'(first), 32'(exp_first));
    checkOutput("contend_ack_spacing", 32'(gap), 32'd3);
    v = '{1'b0, 1'b0, 8'h30, 8'h00, 8'h11};
    applyStimulus(v);
    v = '{1'b1, 1'b0, 8'h31, 8'h00, 8'h22};
    applyStimulus(v);

    // Locked three-beat stack push by port 1 while port 0 waits.
    tick();
    b = 0;
    expect_on(1'b1, 1'b1, 8'hFF, 8'h00);
    setPort(1'b1, 1'b1, 1'b1, 8'hFF, 8'h42, 1'b1);
    tick();
    expect_on(1'b0, 1'b0, 8'hFD, 8'h44);
    setPort(1'b0, 1'b1, 1'b0, 8'hFD, 8'h00, 1'b0);
    base0 = ack_cnt[0]; base1 = ack_cnt[1]; budget = 0; busy_at = -1;
    while (ack_cnt[0] == base0 && budget < 40) begin
      tick();
      budget++;
      if (cyc == busy_at) begin
        checkOutput("locked_idle_busy", 32'(bus.busy), 32'd1);
        checkOutput("locked_idle_owner", 32'(bus.owner), 32'd1);
      end
      if (bus.p1_ack) begin
        b++;
        if (b == 1) busy_at = cyc + 1;
        if (b < 3) begin
          expect_on(1'b1, 1'b1, 8'hFF - 8'(b), 8'h00);
          setPort(1'b1, 1'b1, 1'b1, 8'hFF - 8'(b), 8'h42 + 8'(b), (b < 2));
        end else begin
          setPort(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        end
      end
      if (bus.p0_ack) begin
        checkOutput("lock_p1_beats_before_p0", 32'(ack_cnt[1] - base1), 32'd3);
        setPort(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      end
    end
    checkOutput("lock_p0_served", 32'(ack_cnt[0] - base0), 32'd1);

    // Port 0 keeps lock=1 for six beats; LOCK_MAX forces a release after four.
    tick();
    pb = 0;
    expect_on(1'b0, 1'b1, 8'h50, 8'h00);
    setPort(1'b0, 1'b1, 1'b1, 8'h50, 8'h60, 1'b1);
    tick();
    expect_on(1'b1, 1'b0, 8'h53, 8'h63);
    setPort(1'b1, 1'b1, 1'b0, 8'h53, 8'h00, 1'b0);
    base0 = ack_cnt[0]; base1 = ack_cnt[1]; budget = 0;
    while ((pb < 6 || ack_cnt[1] == base1) && budget < 80) begin
      tick();
      budget++;
      if (bus.p0_ack) begin
        pb++;
        if (pb < 6) begin
          expect_on(1'b0, 1'b1, 8'h50 + 8'(pb), 8'h00);
          setPort(1'b0, 1'b1, 1'b1, 8'h50 + 8'(pb), 8'h60 + 8'(pb), 1'b1);
        end else begin
          setPort(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        end
      end
      if (bus.p1_ack) begin
        checkOutput("lockmax_p0_beats_before_p1", 32'(ack_cnt[0] - base0), 32'd4);
        setPort(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      end
    end
    checkOutput("lockmax_p0_total", 32'(ack_cnt[0] - base0), 32'd6);
    checkOutput("lockmax_p1_total", 32'(ack_cnt[1] - base1), 32'd1);
    // Lock still held after the last beat, released once the owner is idle.
    tick();
    checkOutput("lock_held_after_last_beat", 32'(bus.busy), 32'd1);
    tick();
    checkOutput("lock_drop_release", 32'(bus.busy), 32'd0);
    v = '{1'b1, 1'b0, 8'h55, 8'h00, 8'h65};
    applyStimulus(v);

    // Reset arriving while a write is in ACCESS.
    tick();
    setPort(1'b0, 1'b1, 1'b1, 8'h40, 8'hFF, 1'b0);
    tick();
    checkOutput("abort_in_access_write", 32'(bus.mem_write), 32'd1);
    rst = 1'b1;
    setPort(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    base0 = ack_cnt[0];
    tick();
    checkZeroOutputs("abort");
    rst = 1'b0;
    budget = write_cycles;
    repeat (4) tick();
    checkOutput("abort_no_write_after", 32'(write_cycles - budget), 32'd0);
    checkOutput("abort_no_ack", 32'(ack_cnt[0] - base0), 32'd0);
    v = '{1'b1, 1'b0, 8'h40, 8'h00, 8'h00};
    applyStimulus(v);

    checkOutput("scoreboard_drained", 32'(sb0.size() + sb1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 8-bit DataMemory between two requesters.
- Port 0 is the CPU execute stage: LOAD/STORE/PUSH/POP. Port 1 is the interrupt sequencer: PC/flag push to the stack at 0xFF downward, and the vector fetch from M[0x01].
- Provides a 3-state FSM, one transaction in flight, registered memory command, and a per-port ack with captured read data.
- Supports a lock for atomic multi-beat sequences, bounded by a lock-beat counter.

Parameters:
- ADDR_W, 8, address width; matches DataMemory.
- DATA_W, 8, data width.
- LOCK_MAX, 4, maximum consecutive locked transactions before the lock is forcibly released; range 1..15.
- FIXED_WINNER, 1, winning port when both request and DMEM_ARB_RR_EN is undefined.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- p0_req  in  1  port 0 transaction request, level.
- p0_we  in  1  1 = write, 0 = read.
- p0_addr  in  ADDR_W  port 0 address.
- p0_wdata  in  DATA_W  port 0 write data.
- p0_lock  in  1  keep ownership after this transaction.
- p0_ack  out  1  one-cycle completion pulse.
- p0_rdata  out  DATA_W  read data; valid while p0_ack=1.
- p1_req, p1_we, p1_addr, p1_wdata, p1_lock, p1_ack, p1_rdata: same as port 0, for port 1.
- mem_read  out  1  to DataMemory mem_read.
- mem_write  out  1  to DataMemory mem_write.
- mem_addr  out  ADDR_W  to DataMemory addr.
- mem_wdata  out  DATA_W  to DataMemory data_in.
- mem_rdata  in  DATA_W  from DataMemory data_out; combinational read.
- busy  out  1  FSM not in IDLE, or a lock is held.
- owner  out  1  port of the current or last grant.

Behaviour:
- Reset: the rising edge with rst=1 forces the following, regardless of state:
  - FSM to IDLE.
  - All outputs to 0: mem_*, p*_ack, p*_rdata, busy, owner.
  - lock_active=0, lock_cnt=0, rr_ptr=0.
  - An in-flight transaction is aborted. No mem_write is asserted in any cycle after the reset edge.
- All outputs are registered. mem_* are high only in ACCESS.
- IDLE:
  - Eligible ports: if lock_active, only the owner; otherwise any port with req=1.
  - With an eligible request: latch the winner's we/addr/wdata/lock, set owner, go to ACCESS.
  - With no eligible request: stay in IDLE.
- ACCESS (exactly 1 cycle):
  - Drive mem_addr/mem_wdata from the latched values, and mem_write=we or mem_read=!we.
  - For a read, capture mem_rdata into the winner's rdata register at the end of the cycle.
  - Go to RESP.
- RESP (exactly 1 cycle):
  - Winner's ack=1 with rdata valid; the other port's ack=0 and its rdata holds its last value.
  - Lock update:
    - If latched lock=1 and lock_cnt+1 < LOCK_MAX: lock_active=1, lock_cnt++.
    - Otherwise: lock_active=0, lock_cnt=0.
  - Return to IDLE.
- Latency and throughput:
  - req seen in IDLE at cycle N, then ACCESS at N+1, then ack at N+2.
  - Peak rate is one transaction per 3 cycles.
- Requester rule:
  - On the edge where it sees ack=1, the requester updates addr/we/wdata/lock for the next beat, or drops req.
  - A req still high in the following IDLE cycle is a new transaction.
  - Changes to a request's fields after grant are ignored.
- Lock released by owner drop: if lock_active and the owner's req=0 in IDLE, clear lock_active and lock_cnt and arbitrate normally in the same cycle.
- Simultaneous requests are resolved per the optional feature. The losing port's req is held, never dropped or acked.
- Addresses are used unmodified. No wrap or range check; 0x00 and 0xFF are ordinary.

Optional Feature:
- Macro: DMEM_ARB_RR_EN.
- Defined:
  - Round-robin; rr_ptr names the preferred port on contention.
  - rr_ptr is set to the other port in every RESP whose transaction ends the ownership (lock not continued).
- Undefined:
  - FIXED_WINNER always wins on contention; rr_ptr is absent.
  - The lock still applies.

Decomposition:
- Shared package dmem_arb_pkg:
  - FSM state encoding: IDLE=2'd0, ACCESS=2'd1, RESP=2'd2.
  - Port index constants PORT_CPU=0, PORT_IRQ=1.
  - Defaults for ADDR_W/DATA_W.
- One sub-module, arb_pick: combinational two-way picker taking req[1:0], lock_active, owner, and rr_ptr/FIXED_WINNER, and returning grant and a valid flag. The FSM, latches and lock counter stay in dmem_arbiter.

Test Plan:
- Bench drives rst, holds it one cycle, then releases. DataMemory rst_n is tied to ~rst.
- Scenario 1: Reset, then p1 reads 0x01 -> p1_ack exactly 2 cycles after the IDLE sample, p1_rdata=0x80, p0_ack stays 0.
- Scenario 2: p0 writes 0xAA to 0x10, then p0 reads 0x10 -> mem_write high exactly 1 cycle; read returns 0xAA; each ack is 1 cycle.
- Scenario 3: p0 and p1 request in the same cycle (p0 write 0x11 to 0x30, p1 write 0x22 to 0x31):
  - With RR, rr_ptr=0 -> p0 acked first, then p1.
  - Without RR -> p1 acked first.
  - Readback gives 0x11 and 0x22.
- Scenario 4: p1 locked 3-beat push (0xFF=0x42, 0xFE=0x43, 0xFD=0x44) with p0 requesting throughout -> no p0 ack until after p1's third ack (lock=0 on the last beat); then p0 is served.
- Scenario 5: LOCK_MAX=4, p0 holds lock=1 for 6 beats while p1 requests -> p1 granted after p0's 4th ack; p0 resumes afterwards.
- Scenario 6: rst asserted while in ACCESS of a p0 write of 0xFF to 0x40 -> all outputs 0 next cycle, no ack issued, M[0x40] remains 0x00.
